// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (IFU m0, LSU m1) to single-memory-port arbiter.
// One transaction outstanding at a time: IDLE -> REQ -> WAIT -> RESP -> IDLE.
// Optional build macro MEM_ARBITER_ROUND_ROBIN_EN: alternate grants on contention
// instead of the default fixed priority (m1 wins).
module mem_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  // IFU (read-only)
  input  logic             m0_req_valid,
  output logic             m0_req_ready,
  input  logic [WIDTH-1:0] m0_req_addr,
  output logic             m0_resp_valid,
  input  logic             m0_resp_ready,
  output logic [WIDTH-1:0] m0_resp_data,
  // LSU
  input  logic             m1_req_valid,
  output logic             m1_req_ready,
  input  logic [WIDTH-1:0] m1_req_addr,
  input  logic             m1_req_wen,
  input  logic [WIDTH-1:0] m1_req_wdata,
  input  logic [3:0]       m1_req_wmask,
  output logic             m1_resp_valid,
  input  logic             m1_resp_ready,
  output logic [WIDTH-1:0] m1_resp_data,
  // Memory
  output logic             s_req_valid,
  input  logic             s_req_ready,
  output logic [WIDTH-1:0] s_addr,
  output logic             s_wen,
  output logic [WIDTH-1:0] s_wdata,
  output logic [3:0]       s_wmask,
  input  logic             s_resp_valid,
  output logic             s_resp_ready,
  input  logic [WIDTH-1:0] s_resp_data
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic             grant_q, grant_d;  // 1 = m1 owns the transaction
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             wen_q, wen_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       wmask_q, wmask_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             pick;              // master chosen in this IDLE cycle, 1 = m1

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  // On contention favour whichever master was not granted last time
  always_comb begin
    if (m0_req_valid && m1_req_valid) pick = ~last_grant_q;
    else                              pick = m1_req_valid;
  end
`else
  // Fixed priority: the LSU wins whenever it is requesting
  always_comb begin
    pick = m1_req_valid;
  end
`endif

  // Next-state, latched-field updates and handshake outputs
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    rdata_d       = rdata_q;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    last_grant_d  = last_grant_q;
`endif
    m0_req_ready  = 1'b0;
    m1_req_ready  = 1'b0;
    s_req_valid   = 1'b0;
    s_resp_ready  = 1'b0;
    m0_resp_valid = 1'b0;
    m1_resp_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (m0_req_valid || m1_req_valid) begin
          m0_req_ready = ~pick;
          m1_req_ready = pick;
          grant_d      = pick;
          addr_d       = pick ? m1_req_addr : m0_req_addr;
          wen_d        = pick & m1_req_wen;
          wdata_d      = pick ? m1_req_wdata : '0;
          wmask_d      = pick ? m1_req_wmask : 4'h0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
          last_grant_d = pick;
`endif
          state_d      = StReq;
        end
      end
      StReq: begin
        s_req_valid = 1'b1;
        if (s_req_ready) state_d = StWait;
      end
      StWait: begin
        s_resp_ready = 1'b1;
        if (s_resp_valid) begin
          rdata_d = s_resp_data;
          state_d = StResp;
        end
      end
      StResp: begin
        m0_resp_valid = ~grant_q;
        m1_resp_valid = grant_q;
        if (grant_q ? m1_resp_ready : m0_resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Hold every handshake output low while reset is asserted
    if (rst) begin
      m0_req_ready  = 1'b0;
      m1_req_ready  = 1'b0;
      s_req_valid   = 1'b0;
      s_resp_ready  = 1'b0;
      m0_resp_valid = 1'b0;
      m1_resp_valid = 1'b0;
    end
  end

  // State and latched request/response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= 4'h0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // Last-grant pointer; resets to "m1 last" so the first contention goes to m0
  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end
`endif

  assign s_addr       = addr_q;
  assign s_wen        = wen_q;
  assign s_wdata      = wdata_q;
  assign s_wmask      = wmask_q;
  assign m0_resp_data = rdata_q;
  assign m1_resp_data = rdata_q;

endmodule
